// File: rtl/pixgen_pkg.sv
// Shared definitions for the indexed-colour pixel generator:
// opcodes, colour width, default palette and reset background.
package pixgen_pkg;

    localparam int RGB_W = 12;

    localparam logic [7:0] OP_SET_BG      = 8'h01;
    localparam logic [7:0] OP_BG_RED      = 8'h02;
    localparam logic [7:0] OP_BG_GREEN    = 8'h03;
    localparam logic [7:0] OP_BG_BLUE     = 8'h04;
    localparam logic [7:0] OP_BG_BLACK    = 8'h05;
    localparam logic [7:0] OP_BG_WHITE    = 8'h06;
    localparam logic [7:0] OP_SET_PIXEL   = 8'h07;
    localparam logic [7:0] OP_SET_PALETTE = 8'h08;
    localparam logic [7:0] OP_FILL        = 8'h09;

    localparam logic [RGB_W-1:0] RESET_BG = 12'hf00;

    // Entry 0 in the least significant 12 bits.
    localparam logic [8*RGB_W-1:0] DEFAULT_PALETTE = {
        12'hff0, 12'h0ff, 12'hf0f, 12'h00f,
        12'h0f0, 12'hf00, 12'hfff, 12'h000
    };

    typedef enum logic {
        FILL_IDLE,
        FILL_RUN
    } fill_state_t;

    // Reset colour of a palette entry; entries beyond the default eight are black.
    function automatic logic [RGB_W-1:0] default_color(input int i);
        if (i < 8) begin
            return DEFAULT_PALETTE[i*RGB_W +: RGB_W];
        end
        return '0;
    endfunction

endpackage

// File: rtl/pixgen_palette.sv
// Palette register file: 2^BPP entries of RGB444, one synchronous write
// port and one combinational read port.
module pixgen_palette
    import pixgen_pkg::*;
#(
    parameter int BPP = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             wr_en,
    input  logic [BPP-1:0]   wr_addr,
    input  logic [RGB_W-1:0] wr_data,
    input  logic [BPP-1:0]   rd_addr,
    output logic [RGB_W-1:0] rd_data
);

    localparam int ENTRIES = 1 << BPP;

    logic [RGB_W-1:0] pal_reg [ENTRIES];

    // Palette storage: default colours on reset, single-entry write otherwise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pal_reg[i] <= default_color(i);
            end
        end else if (wr_en) begin
            pal_reg[wr_addr] <= wr_data;
        end
    end

    assign rd_data = pal_reg[rd_addr];

endmodule

// File: rtl/indexed_pixel_generator.sv
// Indexed-colour pixel generator: framebuffer of palette indices scanned in
// step with VGA strobes, with a host instruction port and a row-per-cycle fill.
// Optional feature: define PIXGEN_TEST_PATTERN_EN to reset the framebuffer to
// vertical colour bars (index = x mod 2^BPP) instead of all zeros.
module indexed_pixel_generator
    import pixgen_pkg::*;
#(
    parameter int FB_W    = 30,
    parameter int FB_H    = 20,
    parameter int BPP     = 3,
    parameter int Y_SCALE = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_vsync,
    input  logic             i_hsync,
    input  logic             i_screen_reset,
    input  logic             i_pixel_x_clock,
    input  logic             i_pixel_y_clock,
    input  logic [31:0]      i_instruction,
    input  logic             i_instruction_ready,
    output logic [RGB_W-1:0] o_color,
    output logic             o_busy
);

    localparam int XW = (FB_W > 1) ? $clog2(FB_W) : 1;
    localparam int YW = (FB_H > 1) ? $clog2(FB_H) : 1;
    localparam logic [8:0] FB_W_L   = 9'(FB_W);
    localparam logic [8:0] FB_H_L   = 9'(FB_H);
    localparam logic [7:0] SUB_LAST = 8'(Y_SCALE - 1);
    localparam logic [7:0] LAST_ROW = 8'(FB_H - 1);

    logic [31:0]      instr_reg;
    logic             instr_valid_reg;
    logic [8:0]       x_reg, x_next, y_reg, y_next;
    logic [7:0]       sub_reg, sub_next;
    logic [RGB_W-1:0] bg_color_reg, pending_bg_reg, color_reg, color_next;
    fill_state_t      fill_state_reg, fill_state_next;
    logic [7:0]       fill_row_reg;
    logic [BPP-1:0]   fill_idx_reg;
    logic [BPP-1:0]   fb_reg [FB_H][FB_W];

    // Decoded fields of the instruction being executed this cycle.
    logic [7:0]       opcode;
    logic [7:0]       pix_x, pix_y;
    logic [BPP-1:0]   pix_idx;
    logic             pix_we, pal_we, fill_start, fill_we, in_area;
    logic [BPP-1:0]   rd_idx;
    logic [RGB_W-1:0] pal_rd;
    logic             unused_instr_bits;

    assign opcode     = instr_reg[7:0];
    assign pix_x      = instr_reg[15:8];
    assign pix_y      = instr_reg[23:16];
    assign pix_idx    = instr_reg[24 +: BPP];
    assign pix_we     = instr_valid_reg && (opcode == OP_SET_PIXEL)
                        && ({1'b0, pix_x} < FB_W_L) && ({1'b0, pix_y} < FB_H_L);
    assign pal_we     = instr_valid_reg && (opcode == OP_SET_PALETTE);
    assign fill_start = instr_valid_reg && (opcode == OP_FILL);
    assign fill_we    = (fill_state_reg == FILL_RUN);
    assign o_busy     = fill_we;
    assign o_color    = color_reg;
    // Not every instruction bit is meaningful for every opcode/BPP.
    assign unused_instr_bits = ^instr_reg;

    pixgen_palette #(
        .BPP (BPP)
    ) u_palette (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .wr_en   (pal_we),
        .wr_addr (instr_reg[20 +: BPP]),
        .wr_data (instr_reg[19:8]),
        .rd_addr (rd_idx),
        .rd_data (pal_rd)
    );

    // Capture an instruction only while no fill is running; execute next edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            instr_reg       <= '0;
            instr_valid_reg <= 1'b0;
        end else begin
            instr_valid_reg <= i_instruction_ready && !o_busy;
            if (i_instruction_ready && !o_busy) begin
                instr_reg <= i_instruction;
            end
        end
    end

    // Fill sequencer next state: a FILL (re)starts at row 0, ends after the last row.
    always_comb begin
        fill_state_next = fill_state_reg;
        case (fill_state_reg)
            FILL_IDLE: if (fill_start) fill_state_next = FILL_RUN;
            FILL_RUN: begin
                if (!fill_start && fill_row_reg == LAST_ROW) begin
                    fill_state_next = FILL_IDLE;
                end
            end
            default: fill_state_next = FILL_IDLE;
        endcase
    end

    // Fill sequencer state, current row and fill index.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fill_state_reg <= FILL_IDLE;
            fill_row_reg   <= '0;
            fill_idx_reg   <= '0;
        end else begin
            fill_state_reg <= fill_state_next;
            if (fill_start) begin
                fill_row_reg <= '0;
                fill_idx_reg <= instr_reg[8 +: BPP];
            end else if (fill_we) begin
                fill_row_reg <= fill_row_reg + 8'd1;
            end
        end
    end

    // Framebuffer: fill row has priority over a single-pixel write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < FB_H; r++) begin
                for (int c = 0; c < FB_W; c++) begin
`ifdef PIXGEN_TEST_PATTERN_EN
                    fb_reg[r][c] <= BPP'(c);
`else
                    fb_reg[r][c] <= '0;
`endif
                end
            end
        end else begin
            for (int r = 0; r < FB_H; r++) begin
                for (int c = 0; c < FB_W; c++) begin
                    if (fill_we && fill_row_reg == 8'(r)) begin
                        fb_reg[r][c] <= fill_idx_reg;
                    end else if (pix_we && pix_y == 8'(r) && pix_x == 8'(c)) begin
                        fb_reg[r][c] <= pix_idx;
                    end
                end
            end
        end
    end

    // Background colours: host sets the pending value, vsync makes it visible.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending_bg_reg <= RESET_BG;
            bg_color_reg   <= RESET_BG;
        end else begin
            if (i_vsync) begin
                bg_color_reg <= pending_bg_reg;
            end
            if (instr_valid_reg) begin
                case (opcode)
                    OP_SET_BG:   pending_bg_reg <= instr_reg[19:8];
                    OP_BG_RED:   pending_bg_reg <= 12'hf00;
                    OP_BG_GREEN: pending_bg_reg <= 12'h0f0;
                    OP_BG_BLUE:  pending_bg_reg <= 12'h00f;
                    OP_BG_BLACK: pending_bg_reg <= 12'h000;
                    OP_BG_WHITE: pending_bg_reg <= 12'hfff;
                    default:     pending_bg_reg <= pending_bg_reg;
                endcase
            end
        end
    end

    // Scan counters: screen reset dominates; x and y saturate one past the edge.
    always_comb begin
        x_next   = x_reg;
        y_next   = y_reg;
        sub_next = sub_reg;
        if (i_screen_reset) begin
            x_next   = '0;
            y_next   = '0;
            sub_next = '0;
        end else begin
            if (i_hsync) begin
                x_next = '0;
            end else if (i_pixel_x_clock && x_reg != FB_W_L) begin
                x_next = x_reg + 9'd1;
            end
            if (i_pixel_y_clock) begin
                if (sub_reg == SUB_LAST) begin
                    sub_next = '0;
                    if (y_reg != FB_H_L) begin
                        y_next = y_reg + 9'd1;
                    end
                end else begin
                    sub_next = sub_reg + 8'd1;
                end
            end
        end
    end

    // Pixel colour from the next-state position, background outside the framebuffer.
    always_comb begin
        in_area    = (x_next < FB_W_L) && (y_next < FB_H_L);
        rd_idx     = '0;
        color_next = bg_color_reg;
        if (in_area) begin
            rd_idx     = fb_reg[y_next[YW-1:0]][x_next[XW-1:0]];
            color_next = pal_rd;
        end
    end

    // Scan position and output colour registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_reg     <= '0;
            y_reg     <= '0;
            sub_reg   <= '0;
            color_reg <= '0;
        end else begin
            x_reg     <= x_next;
            y_reg     <= y_next;
            sub_reg   <= sub_next;
            color_reg <= color_next;
        end
    end

endmodule

// File: doc/indexed_pixel_generator.md
# indexed_pixel_generator

Parametrised successor to the fixed 30×20 indexed-colour pixel generator. Holds a `FB_W`×`FB_H` framebuffer of `BPP`-bit palette indices and a writable 2^`BPP`-entry 12-bit palette. It scans the framebuffer in step with the VGA timing strobes, with vertical pixel replication by `Y_SCALE`, and executes 32-bit host instructions: set pixel, set palette, background colour and fill. Pixels outside the framebuffer area show the background colour.

## Interface
- `FB_W`, 30, framebuffer width in pixels (1..256)
- `FB_H`, 20, framebuffer height in pixels (1..256)
- `BPP`, 3, bits per pixel index (1..8)
- `Y_SCALE`, 16, display lines per framebuffer row (1..256)
- `i_clk` in 1: pixel-domain clock, all logic on rising edge
- `i_rst_n` in 1: asynchronous, active-low reset
- `i_vsync` in 1: one-cycle strobe; latches pending background colour
- `i_hsync` in 1: one-cycle strobe; clears column counter
- `i_screen_reset` in 1: one-cycle strobe; clears column, row and sub-line counters
- `i_pixel_x_clock` in 1: advance one column
- `i_pixel_y_clock` in 1: advance one display line
- `i_instruction` in 32: opcode [7:0], args [31:8]
- `i_instruction_ready` in 1: instruction valid this cycle
- `o_color` out 12: RGB444 pixel colour, registered
- `o_busy` out 1: fill in progress; instructions are dropped

## Operation
- Reset: all counters 0; `o_color`=12'h000; `bg_color` and `pending_bg` =12'hf00; `o_busy`=0.
- Reset palette, index 0..7: 000, fff, f00, 0f0, 00f, f0f, 0ff, ff0. Entries ≥8 reset to 000.
- Framebuffer reset content is set by the Configuration macro.
- Instruction path: the word is captured when `i_instruction_ready`=1 and `o_busy`=0, then executed on the following edge.
- Opcode 0x01 SET_BG: `pending_bg`←args[11:0].
- Opcodes 0x02–0x06 set `pending_bg` to the fixed colours f00, 0f0, 00f, 000 and fff respectively.
- Opcode 0x07 SET_PIXEL: x=[15:8], y=[23:16], idx=[31:24] (low `BPP` bits are used). Ignored if x≥`FB_W` or y≥`FB_H`.
- Opcode 0x08 SET_PALETTE: entry [27:20] (low `BPP` bits) ← colour [19:8].
- Opcode 0x09 FILL: idx=[15:8]. Writes one full row per cycle, rows 0..`FB_H`-1. `o_busy`=1 for exactly `FB_H` cycles.
- Unknown opcodes are no-ops.
- Scan, priority per cycle:
  - `i_screen_reset` clears x, y and sub, overriding all other strobes.
  - Otherwise `i_hsync` clears x; else `i_pixel_x_clock` increments x, saturating at `FB_W`.
  - Independently, `i_pixel_y_clock` increments sub. At sub=`Y_SCALE`-1, sub←0 and y increments, saturating at `FB_H`.
- `i_vsync`: `bg_color`←`pending_bg`. A SET_BG executed in the same cycle is not visible until the next vsync.
- Colour: if next_x<`FB_W` and next_y<`FB_H`, colour = palette[fb[next_y][next_x]]; otherwise colour = `bg_color`.

## Timing
- `o_color` is recomputed every cycle from the next-state counters, so it changes on the same edge the counters advance (1-cycle latency from strobe).
- Instruction latency: 2 edges from `i_instruction_ready` to the framebuffer or palette update. The display reflects the change on the following edge.
- A write to the pixel being displayed in the same cycle: display shows the old value that cycle.
- Fill: `o_busy` rises on the edge that executes FILL and falls `FB_H` edges later.
- `i_instruction_ready` during `o_busy` is dropped; there is no queue.
- Scanning continues during a fill; partially filled rows are visible.
- `i_rst_n` low mid-fill aborts the fill: `o_busy`→0 immediately and the framebuffer returns to its reset content.

## Configuration
- `PIXGEN_TEST_PATTERN_EN` defined: framebuffer reset content fb[y][x]=x mod 2^`BPP` (vertical colour bars).
- Not defined: framebuffer resets to all-zero indices.

## Structure
- Package `pixgen_pkg`: opcode localparams 0x01–0x09, RGB444 width 12, default 8-entry palette constant, reset background 12'hf00.
- Sub-module `pixgen_palette`: 2^`BPP`×12 register file with async reset, one synchronous write port and one combinational read port.
- Framebuffer, counters, fill engine and instruction decode stay in the top level.

## Test plan
- Reset, then `i_screen_reset`, 4 x-clocks, default params with test pattern -> `o_color` sequence 000, fff, f00, 0f0, 00f.
- SET_PALETTE entry 1=0x123, then SET_PIXEL (0,0,1), `i_screen_reset` -> `o_color`=0x123.
- SET_BG 0xabc, then x-clock ×31 -> `o_color` stays f00 until `i_vsync`, then abc once x≥30.
- 16 y-clocks -> row advances exactly once. 20×16 y-clocks -> y saturates and `o_color`=`bg_color`.
- FILL idx 2 -> `o_busy` high 20 cycles; SET_PIXEL issued while busy is dropped; afterwards all in-range pixels =f00.
- `i_rst_n` low at fill cycle 5 -> `o_busy`=0 immediately; pattern restored.
